// File: rtl/fb_row_fetcher.sv
// fb_row_fetcher
//
// Read-side stage of the dual-port framebuffer RAM. On a row request it
// issues one read per framebuffer word of that row on RAM Port B, follows
// the fixed RAM read latency with a valid shift register and catches the
// returned words in a small first-word-fall-through FIFO. The panel shifter
// drains that FIFO through a valid/ready stream. A read is only issued when
// the FIFO is guaranteed to have room for it once it returns, so a stalled
// consumer never causes returned RAM data to be lost.
//
// Optional feature macro: FB_ROWFETCH_WRAP_EN
//   defined   : continuous scan; after a row's last word is accepted the
//               next row (ROWS-1 wraps to 0) is fetched without a new
//               RowStart, and RowBusy stays high.
//   undefined : one row per accepted RowStart, back to IDLE after each row.
//
// Ports
//   Clk            in   sole clock (also RAM Port B clock)
//   Reset          in   synchronous, active-high
//   RowStart       in   one-cycle request to fetch row RowIndex (IDLE only)
//   RowIndex       in   row to fetch, sampled with RowStart
//   RamAddr        out  RAM Port B address, registered, holds between reads
//   RamReadEnable  out  RAM Port B read issued this cycle, registered
//   RamDataIn      in   RAM Port B read data
//   WordData       out  FIFO head word (zero while FIFO is empty)
//   WordValid      out  WordData valid
//   WordReady      in   consumer accepts when WordValid & WordReady
//   RowBusy        out  high from accepted RowStart until after RowDone
//   RowDone        out  one-cycle pulse in the cycle the row's last word is
//                       accepted
//   DbgState       out  current FSM state (IDLE=0, FETCH=1, DRAIN=2)
//
// Stream handshake: a word transfers in every cycle where WordValid and
// WordReady are both high; WordValid never depends on WordReady, and
// WordData/WordValid stay stable until the transfer happens.

module fb_row_fetcher #(
   parameter int DATAWIDTH     = 256,
   parameter int ADDRWIDTH     = 16,
   parameter int LATENCY       = 2,
   parameter int WORDS_PER_ROW = 4,
   parameter int ROWS          = 8,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                                  Clk,
   input  logic                                  Reset,
   input  logic                                  RowStart,
   input  logic [$clog2(ROWS > 1 ? ROWS : 2)-1:0] RowIndex,
   output logic [ADDRWIDTH-1:0]                  RamAddr,
   output logic                                  RamReadEnable,
   input  logic [DATAWIDTH-1:0]                  RamDataIn,
   output logic [DATAWIDTH-1:0]                  WordData,
   output logic                                  WordValid,
   input  logic                                  WordReady,
   output logic                                  RowBusy,
   output logic                                  RowDone,
   output logic [1:0]                            DbgState
);

   localparam int ROW_W = $clog2(ROWS > 1 ? ROWS : 2);
   localparam int CNT_W = $clog2(WORDS_PER_ROW + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ADDRWIDTH-1:0] addr_q, addr_d;
   logic                 ren_q, ren_d;
   logic [LATENCY-1:0]   pipe_q, pipe_d;

   logic [DATAWIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]       fcnt_q;

   logic                 start, credit, issue, last, push, pop, row_end;
   logic [ROW_W-1:0]     cur_row;
   logic [CNT_W-1:0]     cur_cnt;
   logic [31:0]          inflight, addr_full;

   // Reads already committed but not yet in the FIFO: the one on the RAM
   // port this cycle plus every stage of the latency pipe (including the
   // stage that is being written into the FIFO at this edge).
   always_comb begin
      inflight = {31'd0, ren_q};
      for (int i = 0; i < LATENCY; i++) begin
         inflight = inflight + {31'd0, pipe_q[i]};
      end
   end

   assign credit = (32'(fcnt_q) + inflight) < 32'(FIFO_DEPTH);

   // The read for word 0 is registered in the same edge that accepts
   // RowStart, so the row and word number come straight from the request.
   assign start     = (state_q == IDLE) && RowStart;
   assign cur_row   = start ? RowIndex : row_q;
   assign cur_cnt   = start ? '0 : cnt_q;
   assign issue     = (start || (state_q == FETCH)) && credit;
   assign last      = (cur_cnt == CNT_W'(WORDS_PER_ROW - 1));
   assign addr_full = 32'(cur_row) * 32'(WORDS_PER_ROW) + 32'(cur_cnt);
   assign addr_d    = issue ? addr_full[ADDRWIDTH-1:0] : addr_q;
   assign ren_d     = issue;
   // Oldest stage drops off the top; the read on the port enters stage 0.
   assign pipe_d    = LATENCY'({pipe_q, ren_q});

   assign push      = pipe_q[LATENCY-1];
   assign WordValid = (fcnt_q != '0);
   assign pop       = WordValid && WordReady;
   assign WordData  = WordValid ? mem_q[rd_ptr_q] : '0;

   // In DRAIN every read has been issued, so the row is complete when the
   // only remaining word leaves the FIFO and nothing is still in flight.
   assign row_end   = (state_q == DRAIN) && pop && (fcnt_q == (PTR_W+1)'(1))
                      && (inflight == 32'd0);

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      RowDone = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (RowStart) begin
               row_d   = RowIndex;
               cnt_d   = issue ? CNT_W'(1) : '0;
               state_d = (issue && last) ? DRAIN : FETCH;
            end
         end
         FETCH: begin
            if (issue) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (last) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (row_end) begin
               RowDone = 1'b1;
`ifdef FB_ROWFETCH_WRAP_EN
               row_d   = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
               cnt_d   = '0;
               state_d = FETCH;
`else
               state_d = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         row_q    <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         ren_q    <= 1'b0;
         pipe_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         ren_q    <= ren_d;
         pipe_q   <= pipe_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         fcnt_q <= fcnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

   // FIFO storage needs no reset: entries are only visible while counted.
   always_ff @(posedge Clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= RamDataIn;
      end
   end

   assign RamAddr       = addr_q;
   assign RamReadEnable = ren_q;
   assign RowBusy       = (state_q != IDLE);
   assign DbgState      = state_q;

endmodule
